// File: rtl/w_counter_pkg.sv
// ----------------------------------------------------------------------------
// w_counter_pkg
// Shared constants for the w_updown_counter family:
//   - direction encodings for the 'up' input (DIR_UP / DIR_DOWN)
//   - legal bounds for the WIDTH and MODULUS parameters
//   - modulus_max(): largest legal MODULUS for a given WIDTH (2**WIDTH)
// ----------------------------------------------------------------------------
package w_counter_pkg;

  // Direction encodings for the 'up' input.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Legal parameter bounds.
  localparam int     WIDTH_MIN   = 2;
  localparam int     WIDTH_MAX   = 32;
  localparam longint MODULUS_MIN = 2;

  // Largest legal modulus for a counter of the given width. A 64-bit
  // result is used because 2**32 does not fit in an int.
  function automatic longint modulus_max(input int width);
    return longint'(1) << width;
  endfunction

endpackage : w_counter_pkg

// File: rtl/w_updown_counter.sv
// ----------------------------------------------------------------------------
// w_updown_counter
// Synchronous modulo-N up/down counter with parallel load and cascadable
// terminal count (74x190/74x169 style enable scheme).
//
// Parameters:
//   WIDTH    counter width in bits (2..32)
//   MODULUS  count length (2..2**WIDTH); q spans 0..MODULUS-1
//
// Ports:
//   cp   in   1      clock, all state changes on the rising edge
//   mr   in   1      synchronous active-high reset (highest priority)
//   cep  in   1      parallel count enable
//   cet  in   1      trickle count enable, also gates tc
//   pe   in   1      parallel load enable (beats counting)
//   up   in   1      direction, DIR_UP = increment, DIR_DOWN = decrement
//   d    in   WIDTH  parallel load data, clamped to MODULUS-1
//   q    out  WIDTH  registered count
//   ovf  out  1      sticky wrap flag (only with W_UPDOWN_COUNTER_OVF_EN)
//   tc   out  1      terminal count, combinational from q, cet and up
//
// Optional feature macro: W_UPDOWN_COUNTER_OVF_EN
//   When defined, the registered output ovf is present. It is set on any
//   counting edge that wraps (in either direction) and is cleared by mr or
//   pe. When undefined, neither the port nor its register exists.
//
// Cascading: wire tc of stage n to cet of stage n+1 and share cep; no glue
// logic is needed because tc already includes cet.
// ----------------------------------------------------------------------------
module w_updown_counter
  import w_counter_pkg::*;
#(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic             cp,
  input  logic             mr,
  input  logic             cep,
  input  logic             cet,
  input  logic             pe,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
`ifdef W_UPDOWN_COUNTER_OVF_EN
  output logic             ovf,
`endif
  output logic             tc
);

  // Largest count value. MODULUS-1 always fits in WIDTH bits, so comparing
  // d against Q_MAX is equivalent to d >= MODULUS without widening d.
  localparam logic [WIDTH-1:0] Q_MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] Q_ZERO = '0;
  localparam logic [WIDTH-1:0] Q_ONE  = WIDTH'(1);

  // Reject illegal parameterisations at elaboration time.
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("w_updown_counter: WIDTH out of range");
  end
  if (MODULUS < MODULUS_MIN || MODULUS > modulus_max(WIDTH)) begin : g_bad_modulus
    $error("w_updown_counter: MODULUS out of range");
  end

  always_ff @(posedge cp) begin
    if (mr) begin
      q <= Q_ZERO;
`ifdef W_UPDOWN_COUNTER_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (pe) begin
      // Out-of-range load data saturates so q never leaves 0..MODULUS-1.
      q <= (d > Q_MAX) ? Q_MAX : d;
`ifdef W_UPDOWN_COUNTER_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (cep && cet) begin
      if (up == DIR_UP) begin
        if (q == Q_MAX) begin
          q <= Q_ZERO;
`ifdef W_UPDOWN_COUNTER_OVF_EN
          ovf <= 1'b1;
`endif
        end else begin
          q <= q + Q_ONE;
        end
      end else begin
        if (q == Q_ZERO) begin
          q <= Q_MAX;
`ifdef W_UPDOWN_COUNTER_OVF_EN
          ovf <= 1'b1;
`endif
        end else begin
          q <= q - Q_ONE;
        end
      end
    end
  end

  // Terminal count: last state in the current direction, qualified by cet
  // only (cep deliberately excluded so cascades ripple correctly).
  assign tc = cet & (((up == DIR_UP) & (q == Q_MAX)) | ((up == DIR_DOWN) & (q == Q_ZERO)));

endmodule : w_updown_counter
